// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state type and per-status message-length lookup.
package midi_pkg;

  localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
  localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
  localparam logic [3:0] NIB_POLY_AT  = 4'hA;
  localparam logic [3:0] NIB_CTRL     = 4'hB;
  localparam logic [3:0] NIB_PROG     = 4'hC;
  localparam logic [3:0] NIB_CHAN_AT  = 4'hD;
  localparam logic [3:0] NIB_PITCH    = 4'hE;
  localparam logic [3:0] NIB_SYSTEM   = 4'hF;

  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] MTC_QF       = 8'hF1;
  localparam logic [7:0] SONG_POS     = 8'hF2;
  localparam logic [7:0] SONG_SEL     = 8'hF3;
  localparam logic [7:0] UNDEF_F4     = 8'hF4;
  localparam logic [7:0] UNDEF_F5     = 8'hF5;
  localparam logic [7:0] TUNE_REQ     = 8'hF6;
  localparam logic [7:0] SYSEX_END    = 8'hF7;
  localparam logic [7:0] RT_FIRST     = 8'hF8;
  localparam logic [7:0] RT_UNDEF_F9  = 8'hF9;
  localparam logic [7:0] RT_UNDEF_FD  = 8'hFD;
  localparam logic [7:0] ACTIVE_SENSE = 8'hFE;

  localparam logic [7:0] LEN_SYSEX    = 8'd255;

  typedef enum logic [1:0] {IDLE, MSG, SYSEX} state_e;

  function automatic logic [7:0] msg_len(input logic [7:0] status);
    logic [7:0] len;
    len = 8'd0;
    case (status[7:4])
      NIB_NOTE_OFF, NIB_NOTE_ON, NIB_POLY_AT, NIB_CTRL, NIB_PITCH: len = 8'd2;
      NIB_PROG, NIB_CHAN_AT: len = 8'd1;
      NIB_SYSTEM: begin
        case (status)
          SONG_POS:         len = 8'd2;
          MTC_QF, SONG_SEL: len = 8'd1;
          SYSEX_START:      len = LEN_SYSEX;
          default:          len = 8'd0;
        endcase
      end
      default: len = 8'd0;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/midi_byte_parser_active_sense_timer.sv
// Active-sensing watchdog: once armed, pulses timeout after TIMEOUT_CYCLES idle cycles.
module active_sense_timer
  import midi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic kick,
  output logic timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             armed;
  logic [CNT_W-1:0] cnt;

  // Combinational so the parser can register sense_lost on the TIMEOUT_CYCLES-th idle edge.
  assign timeout = armed && !kick && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (arm || (armed && kick)) begin
      armed <= 1'b1;
      cnt   <= '0;
    end else if (timeout) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (armed) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/midi_byte_parser.sv
// Frames a raw MIDI byte stream into numbered bytes tagged with their governing status.
module midi_byte_parser
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned SENSE_MS = 300
) (
  input  logic       CLOCK_50,
  input  logic       reset_reg,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       byteready,
  output logic [7:0] cur_status,
  output logic [7:0] midibyte_nr,
  output logic [7:0] midi_in_data,
  output logic       msg_done,
  output logic       rt_valid,
  output logic [7:0] rt_data,
  output logic       sense_lost,
  output logic       err_pulse,
  output logic [7:0] err_count
);

  localparam int unsigned TIMEOUT_CYCLES = CLK_HZ / 1000 * SENSE_MS;

  state_e     state_q, state_d;
  logic [7:0] run_q, run_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] len;
  logic [7:0] gov, nr;
  logic       emit, done, err, rt, timeout, arm;

  assign len = msg_len(run_q);
  assign arm = rx_valid && (rx_data == ACTIVE_SENSE);

  active_sense_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (CLOCK_50),
    .rst    (reset_reg),
    .arm    (arm),
    .kick   (rx_valid),
    .timeout(timeout)
  );

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    gov     = run_q;
    nr      = 8'd0;
    done    = 1'b0;
    err     = 1'b0;
    rt      = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      run_d   = 8'h00;
    end else if (rx_valid) begin
      if (rx_data >= RT_FIRST) begin
        rt = !((rx_data == RT_UNDEF_F9) || (rx_data == RT_UNDEF_FD));
      end else if (rx_data == SYSEX_END) begin
        if (state_q == SYSEX) begin
          emit    = 1'b1;
          gov     = SYSEX_START;
          nr      = sat_inc(cnt_q);
          done    = 1'b1;
          state_d = IDLE;
          run_d   = 8'h00;
          cnt_d   = 8'd0;
        end else begin
          err = 1'b1;
        end
      end else if (rx_data[7]) begin
        // A new status abandons any message still waiting for data bytes.
        err   = (state_q == SYSEX) || ((state_q == MSG) && (cnt_q < len));
        cnt_d = 8'd0;
        if ((rx_data == UNDEF_F4) || (rx_data == UNDEF_F5)) begin
          state_d = IDLE;
          run_d   = 8'h00;
        end else begin
          emit = 1'b1;
          gov  = rx_data;
          if (rx_data == SYSEX_START) begin
            state_d = SYSEX;
            run_d   = rx_data;
          end else if (rx_data == TUNE_REQ) begin
            done    = 1'b1;
            state_d = IDLE;
            run_d   = 8'h00;
          end else begin
            state_d = MSG;
            run_d   = rx_data;
          end
        end
      end else begin
        case (state_q)
          SYSEX: begin
            emit  = 1'b1;
            cnt_d = sat_inc(cnt_q);
            nr    = cnt_d;
          end
          MSG: begin
            emit  = 1'b1;
            cnt_d = (cnt_q >= len) ? 8'd1 : cnt_q + 8'd1;
            nr    = cnt_d;
            done  = (cnt_d == len);
            // System-common messages never hold running status.
            if (done && (run_q[7:4] == NIB_SYSTEM)) begin
              state_d = IDLE;
              run_d   = 8'h00;
              cnt_d   = 8'd0;
            end
          end
          default: err = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
    if (reset_reg) begin
      state_q      <= IDLE;
      run_q        <= 8'h00;
      cnt_q        <= 8'd0;
      byteready    <= 1'b0;
      cur_status   <= 8'h00;
      midibyte_nr  <= 8'd0;
      midi_in_data <= 8'h00;
      msg_done     <= 1'b0;
      rt_valid     <= 1'b0;
      rt_data      <= 8'h00;
      sense_lost   <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      byteready  <= emit;
      msg_done   <= done;
      rt_valid   <= rt;
      sense_lost <= timeout;
      err_pulse  <= err;
      cur_status <= emit ? gov : run_d;
      if (emit) begin
        midibyte_nr  <= nr;
        midi_in_data <= rx_data;
      end
      if (rt) rt_data <= rx_data;
      if (err) err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_midi_byte_parser.sv
// Bench for midi_byte_parser: stream-level reference model plus directed test-plan vectors.
module tb_midi_byte_parser;

  localparam int unsigned CLK_HZ   = 1000;
  localparam int unsigned SENSE_MS = 5;
  localparam int          TIMEOUT  = CLK_HZ / 1000 * SENSE_MS;
  localparam int          M_IDLE = 0, M_MSG = 1, M_SYSEX = 2;

  logic       clk = 1'b0;
  logic       reset_reg = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       byteready, msg_done, rt_valid, sense_lost, err_pulse;
  logic [7:0] cur_status, midibyte_nr, midi_in_data, rt_data, err_count;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [31:0] evq[$];

  midi_byte_parser #(
    .CLK_HZ  (CLK_HZ),
    .SENSE_MS(SENSE_MS)
  ) dut (
    .CLOCK_50    (clk),
    .reset_reg   (reset_reg),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .byteready   (byteready),
    .cur_status  (cur_status),
    .midibyte_nr (midibyte_nr),
    .midi_in_data(midi_in_data),
    .msg_done    (msg_done),
    .rt_valid    (rt_valid),
    .rt_data     (rt_data),
    .sense_lost  (sense_lost),
    .err_pulse   (err_pulse),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ev_br(input logic [7:0] st, input logic [7:0] n,
                                        input logic [7:0] d, input logic dn);
    return {st, n, d, 7'd0, dn};
  endfunction

  function automatic logic [31:0] ev_rt(input logic [7:0] d);
    return {8'hFF, 8'h00, d, 8'h00};
  endfunction

  // Data bytes each status expects; -1 marks open-ended sysex.
  function automatic int exp_len(input logic [7:0] s);
    if (s == 8'hF0) return -1;
    if (s == 8'hF1 || s == 8'hF3 || s[7:4] == 4'hC || s[7:4] == 4'hD) return 1;
    if (s == 8'hF2 || (s >= 8'h80 && s < 8'hF0)) return 2;
    return 0;
  endfunction

  // Reference model: expected outputs after each clock edge.
  logic       e_br = 0, e_done = 0, e_rt = 0, e_sl = 0, e_err = 0;
  logic [7:0] e_st = 0, e_nr = 0, e_data = 0, e_rtd = 0, e_ecnt = 0;
  logic [7:0] m_status = 0, b;
  int         m_mode = M_IDLE, m_cnt = 0, m_silent = 0;
  logic       m_armed = 0;
  logic [7:0] gov;

  always @(posedge clk or posedge reset_reg) begin
    if (reset_reg) begin
      {e_br, e_done, e_rt, e_sl, e_err} = '0;
      {e_st, e_nr, e_data, e_rtd, e_ecnt} = '0;
      m_status = 0; m_mode = M_IDLE; m_cnt = 0; m_armed = 0; m_silent = 0;
    end else begin
      {e_br, e_done, e_rt, e_sl, e_err} = '0;
      gov = 8'h00;
      if (rx_valid) begin
        b = rx_data;
        if (b == 8'hFE || m_armed) begin m_armed = 1; m_silent = 0; end
        if (b >= 8'hF8) begin
          if (b != 8'hF9 && b != 8'hFD) begin e_rt = 1; e_rtd = b; end
        end else if (b == 8'hF7) begin
          if (m_mode == M_SYSEX) begin
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            e_br = 1; gov = 8'hF0; e_nr = 8'(m_cnt); e_data = b; e_done = 1;
            m_mode = M_IDLE; m_status = 0;
          end else e_err = 1;
        end else if (b[7]) begin
          e_err = (m_mode == M_SYSEX) || (m_mode == M_MSG && m_cnt < exp_len(m_status));
          m_cnt = 0;
          if (b == 8'hF4 || b == 8'hF5) begin
            m_mode = M_IDLE; m_status = 0;
          end else begin
            e_br = 1; gov = b; e_nr = 0; e_data = b;
            if (b == 8'hF0) begin m_mode = M_SYSEX; m_status = b; end
            else if (exp_len(b) == 0) begin e_done = 1; m_mode = M_IDLE; m_status = 0; end
            else begin m_mode = M_MSG; m_status = b; end
          end
        end else if (m_mode == M_IDLE) begin
          e_err = 1;
        end else if (m_mode == M_SYSEX) begin
          m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
          e_br = 1; gov = m_status; e_nr = 8'(m_cnt); e_data = b;
        end else begin
          if (m_cnt == exp_len(m_status)) m_cnt = 0;
          m_cnt++;
          e_br = 1; gov = m_status; e_nr = 8'(m_cnt); e_data = b;
          if (m_cnt == exp_len(m_status)) begin
            e_done = 1;
            if (m_status >= 8'hF0) begin m_mode = M_IDLE; m_status = 0; m_cnt = 0; end
          end
        end
      end else if (m_armed) begin
        m_silent++;
        if (m_silent == TIMEOUT) begin
          e_sl = 1; m_armed = 0; m_mode = M_IDLE; m_status = 0;
        end
      end
      if (e_err && e_ecnt != 8'hFF) e_ecnt++;
      e_st = e_br ? gov : m_status;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("byteready", 32'(byteready), 32'(e_br));
      chk("cur_status", 32'(cur_status), 32'(e_st));
      chk("midibyte_nr", 32'(midibyte_nr), 32'(e_nr));
      chk("midi_in_data", 32'(midi_in_data), 32'(e_data));
      chk("msg_done", 32'(msg_done), 32'(e_done));
      chk("rt_valid", 32'(rt_valid), 32'(e_rt));
      chk("rt_data", 32'(rt_data), 32'(e_rtd));
      chk("sense_lost", 32'(sense_lost), 32'(e_sl));
      chk("err_pulse", 32'(err_pulse), 32'(e_err));
      chk("err_count", 32'(err_count), 32'(e_ecnt));
    end
    if (byteready) evq.push_back(ev_br(cur_status, midibyte_nr, midi_in_data, msg_done));
    if (rt_valid) evq.push_back(ev_rt(rt_data));
  end

  task automatic send(input logic [7:0] v);
    rx_valid = 1'b1;
    rx_data  = v;
    @(posedge clk);
    #2 rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_reg = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset_reg = 1'b0;
    evq.delete();
  endtask

  task automatic expect_ev(input string name, input logic [31:0] want);
    logic [31:0] got;
    got = 32'hDEADBEEF;
    if (evq.size() > 0) got = evq.pop_front();
    chk(name, got, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic got;
    repeat (2) @(posedge clk);
    #2 reset_reg = 1'b0;
    chk_en = 1'b1;

    // Running status on note-on
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h50);
    idle(2);
    expect_ev("t1_b0", ev_br(8'h90, 8'd0, 8'h90, 1'b0));
    expect_ev("t1_b1", ev_br(8'h90, 8'd1, 8'h3C, 1'b0));
    expect_ev("t1_b2", ev_br(8'h90, 8'd2, 8'h64, 1'b1));
    expect_ev("t1_b3", ev_br(8'h90, 8'd1, 8'h3E, 1'b0));
    expect_ev("t1_b4", ev_br(8'h90, 8'd2, 8'h50, 1'b1));
    chk("t1_errs", 32'(err_count), 32'd0);

    // One-byte message with interleaved realtime
    do_reset();
    send(8'hC5); send(8'h07); send(8'hF8); send(8'h09);
    idle(2);
    expect_ev("t2_b0", ev_br(8'hC5, 8'd0, 8'hC5, 1'b0));
    expect_ev("t2_b1", ev_br(8'hC5, 8'd1, 8'h07, 1'b1));
    expect_ev("t2_rt", ev_rt(8'hF8));
    expect_ev("t2_b2", ev_br(8'hC5, 8'd1, 8'h09, 1'b1));

    // Sysex bracket, then a stray data byte
    do_reset();
    send(8'hF0); send(8'h41); send(8'h10); send(8'hF9); send(8'hF7); send(8'h22);
    idle(2);
    expect_ev("t3_b0", ev_br(8'hF0, 8'd0, 8'hF0, 1'b0));
    expect_ev("t3_b1", ev_br(8'hF0, 8'd1, 8'h41, 1'b0));
    expect_ev("t3_b2", ev_br(8'hF0, 8'd2, 8'h10, 1'b0));
    expect_ev("t3_b3", ev_br(8'hF0, 8'd3, 8'hF7, 1'b1));
    chk("t3_q_empty", 32'(evq.size()), 32'd0);
    chk("t3_errs", 32'(err_count), 32'd1);
    chk("t3_status", 32'(cur_status), 32'h00);

    // Interrupted message
    do_reset();
    send(8'h90); send(8'h3C); send(8'hB0);
    chk("t4_err_pulse", 32'(err_pulse), 32'd1);
    chk("t4_err_with_br", 32'(byteready), 32'd1);
    send(8'h07); send(8'h7F);
    idle(2);
    expect_ev("t4_b0", ev_br(8'h90, 8'd0, 8'h90, 1'b0));
    expect_ev("t4_b1", ev_br(8'h90, 8'd1, 8'h3C, 1'b0));
    expect_ev("t4_b2", ev_br(8'hB0, 8'd0, 8'hB0, 1'b0));
    expect_ev("t4_b3", ev_br(8'hB0, 8'd1, 8'h07, 1'b0));
    expect_ev("t4_b4", ev_br(8'hB0, 8'd2, 8'h7F, 1'b1));
    chk("t4_errs", 32'(err_count), 32'd1);

    // Active-sensing timeout
    do_reset();
    send(8'h90); send(8'hFE);
    n = 0;
    got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (sense_lost) begin
        got = 1'b1;
        n = i;
      end
    end
    chk("t5_sense_delay", 32'(n), 32'd5);
    chk("t5_status", 32'(cur_status), 32'h00);
    idle(2);
    expect_ev("t5_b0", ev_br(8'h90, 8'd0, 8'h90, 1'b0));
    expect_ev("t5_rt", ev_rt(8'hFE));

    // Reset mid-message
    do_reset();
    send(8'h90);
    reset_reg = 1'b1;
    #1;
    chk("t6_rst_br", 32'(byteready), 32'd0);
    chk("t6_rst_status", 32'(cur_status), 32'h00);
    chk("t6_rst_data", 32'(midi_in_data), 32'h00);
    idle(2);
    reset_reg = 1'b0;
    evq.delete();
    send(8'h3C);
    chk("t6_err_pulse", 32'(err_pulse), 32'd1);
    send(8'hF6);
    idle(2);
    chk("t6_errs", 32'(err_count), 32'd1);
    expect_ev("t6_tune", ev_br(8'hF6, 8'd0, 8'hF6, 1'b1));
    chk("t6_status_after", 32'(cur_status), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
